ri5cy_ahb_arbiter: RTL

//  Shares one AHB-Lite master port between two RI5CY-style memory requesters:

---
 rtl/ri5cy_ahb_arbiter_if.sv | 65 ++++++
 rtl/ri5cy_ahb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ri5cy_ahb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ri5cy_ahb_arbiter_if
//  Brief    : Bus bundle joining two RI5CY requesters and one AHB-Lite port.
//  Revision : 1.0
// ============================================================================
interface ri5cy_ahb_arbiter_if #(
  parameter int AHB_ADDR_WIDTH = 32
);
  logic                      p0_req_i;
  logic                      p0_we_i;
  logic [3:0]                p0_be_i;
  logic [31:0]               p0_addr_i;
  logic [31:0]               p0_wdata_i;
  logic                      p0_gnt_o;
  logic                      p0_rvalid_o;
  logic [31:0]               p0_rdata_o;
  logic                      p0_err_o;

  logic                      p1_req_i;
  logic                      p1_we_i;
  logic [3:0]                p1_be_i;
  logic [31:0]               p1_addr_i;
  logic [31:0]               p1_wdata_i;
  logic                      p1_gnt_o;
  logic                      p1_rvalid_o;
  logic [31:0]               p1_rdata_o;
  logic                      p1_err_o;

  logic                      hsel_o;
  logic [AHB_ADDR_WIDTH-1:0] haddr_o;
  logic                      hwrite_o;
  logic [2:0]                hsize_o;
  logic [2:0]                hburst_o;
  logic [3:0]                hprot_o;
  logic [1:0]                htrans_o;
  logic                      hmastlock_o;
  logic [31:0]               hwdata_o;
  logic [31:0]               hrdata_i;
  logic                      hready_i;
  logic                      hresp_i;

  // Arbiter side: the AHB master.
  modport master (
    input  p0_req_i, p0_we_i, p0_be_i, p0_addr_i, p0_wdata_i,
    output p0_gnt_o, p0_rvalid_o, p0_rdata_o, p0_err_o,
    input  p1_req_i, p1_we_i, p1_be_i, p1_addr_i, p1_wdata_i,
    output p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
    output hsel_o, haddr_o, hwrite_o, hsize_o, hburst_o, hprot_o, htrans_o,
    output hmastlock_o, hwdata_o,
    input  hrdata_i, hready_i, hresp_i
  );

  // Environment side: requesters plus the AHB slave.
  modport slave (
    output p0_req_i, p0_we_i, p0_be_i, p0_addr_i, p0_wdata_i,
    input  p0_gnt_o, p0_rvalid_o, p0_rdata_o, p0_err_o,
    output p1_req_i, p1_we_i, p1_be_i, p1_addr_i, p1_wdata_i,
    input  p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
    input  hsel_o, haddr_o, hwrite_o, hsize_o, hburst_o, hprot_o, htrans_o,
    input  hmastlock_o, hwdata_o,
    output hrdata_i, hready_i, hresp_i
  );
endinterface
`default_nettype wire

// File: rtl/ri5cy_ahb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ri5cy_ahb_arbiter
//  Brief    : Shares one AHB-Lite master port between the RI5CY LSU (port 0)
//             and instruction fetch (port 1), one data phase outstanding.
//  Revision : 1.0
// ============================================================================
module ri5cy_ahb_arbiter #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int ARB_MODE       = 1
) (
  input wire                  clk,
  input wire                  rst,
  ri5cy_ahb_arbiter_if.master bus
);

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] c_HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] c_HSIZE_HALF    = 3'b001;
  localparam logic [2:0] c_HSIZE_WORD    = 3'b010;
  localparam logic [2:0] c_HBURST_SINGLE = 3'b000;

  typedef enum logic [0:0] {
    DP_IDLE = 1'b0,
    DP_DATA = 1'b1
  } dp_state_e;

  dp_state_e                 dp_state_q, dp_state_d;
  logic                      dp_owner_q, dp_owner_d;
  logic                      addr_lock_q, addr_lock_d;
  logic                      lock_owner_q, lock_owner_d;
  logic                      rr_ptr_q, rr_ptr_d;
  logic [AHB_DATA_WIDTH-1:0] hwdata_q, hwdata_d;

  logic                      w_err_first;
  logic                      w_active;
  logic                      w_owner;
  logic                      w_gnt;
  logic                      w_done;
  logic                      w_we;
  logic [3:0]                w_be;
  logic [31:0]               w_addr;
  logic [31:0]               w_wdata;
  logic [2:0]                w_size;
  logic [1:0]                w_addr_lo;
  logic                      w_be_legal;
  logic [31:0]               w_addr_sel;
  logic [AHB_ADDR_WIDTH-1:0] w_haddr;

  // First cycle of a two-cycle ERROR: the pending address phase is withdrawn.
  assign w_err_first = (dp_state_q == DP_DATA) & bus.hresp_i & ~bus.hready_i;

  always_comb begin
    w_active = 1'b0;
    w_owner  = 1'b0;
    if (!rst && !w_err_first) begin
      if (addr_lock_q) begin
        w_active = 1'b1;
        w_owner  = lock_owner_q;
      end else if (bus.p0_req_i && bus.p1_req_i) begin
        w_active = 1'b1;
        w_owner  = (ARB_MODE == 0) ? 1'b0 : rr_ptr_q;
      end else if (bus.p0_req_i) begin
        w_active = 1'b1;
        w_owner  = 1'b0;
      end else if (bus.p1_req_i) begin
        w_active = 1'b1;
        w_owner  = 1'b1;
      end
    end
  end

  assign w_we    = w_owner ? bus.p1_we_i    : bus.p0_we_i;
  assign w_be    = w_owner ? bus.p1_be_i    : bus.p0_be_i;
  assign w_addr  = w_owner ? bus.p1_addr_i  : bus.p0_addr_i;
  assign w_wdata = w_owner ? bus.p1_wdata_i : bus.p0_wdata_i;

  always_comb begin
    w_size     = c_HSIZE_WORD;
    w_addr_lo  = 2'b00;
    w_be_legal = 1'b1;
    case (w_be)
      4'b1111: ;
      4'b0011: w_size = c_HSIZE_HALF;
      4'b1100: begin w_size = c_HSIZE_HALF; w_addr_lo = 2'b10; end
      4'b0001: w_size = c_HSIZE_BYTE;
      4'b0010: begin w_size = c_HSIZE_BYTE; w_addr_lo = 2'b01; end
      4'b0100: begin w_size = c_HSIZE_BYTE; w_addr_lo = 2'b10; end
      4'b1000: begin w_size = c_HSIZE_BYTE; w_addr_lo = 2'b11; end
      default: w_be_legal = 1'b0;
    endcase
  end

  assign w_addr_sel = {w_addr[31:2], w_addr_lo};

  generate
    if (AHB_ADDR_WIDTH > 32) begin : g_addr_ext
      assign w_haddr = {{(AHB_ADDR_WIDTH-32){1'b0}}, w_addr_sel};
    end else begin : g_addr_trunc
      assign w_haddr = w_addr_sel[AHB_ADDR_WIDTH-1:0];
    end
  endgenerate

  assign w_gnt  = w_active & bus.hready_i;
  assign w_done = (dp_state_q == DP_DATA) & bus.hready_i;

  assign bus.htrans_o    = w_active ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
  assign bus.hsel_o      = w_active;
  assign bus.haddr_o     = w_active ? w_haddr : '0;
  assign bus.hwrite_o    = w_active & w_we;
  assign bus.hsize_o     = w_size;
  assign bus.hburst_o    = c_HBURST_SINGLE;
  assign bus.hmastlock_o = 1'b0;
  assign bus.hprot_o     = {2'b00, 1'b1, ~w_owner};
  assign bus.hwdata_o    = hwdata_q;

  assign bus.p0_gnt_o    = w_gnt & ~w_owner;
  assign bus.p1_gnt_o    = w_gnt &  w_owner;
  assign bus.p0_rvalid_o = w_done & ~dp_owner_q;
  assign bus.p1_rvalid_o = w_done &  dp_owner_q;
  assign bus.p0_err_o    = w_done & ~dp_owner_q & bus.hresp_i;
  assign bus.p1_err_o    = w_done &  dp_owner_q & bus.hresp_i;
  assign bus.p0_rdata_o  = bus.hrdata_i;
  assign bus.p1_rdata_o  = bus.hrdata_i;

  // A new grant while completing keeps the tracker in DATA: one transfer per cycle.
  always_comb begin
    dp_state_d   = dp_state_q;
    dp_owner_d   = dp_owner_q;
    hwdata_d     = hwdata_q;
    rr_ptr_d     = rr_ptr_q;
    addr_lock_d  = w_active & ~bus.hready_i;
    lock_owner_d = w_active ? w_owner : lock_owner_q;
    if (w_gnt) begin
      dp_state_d = DP_DATA;
      dp_owner_d = w_owner;
      hwdata_d   = w_wdata;
      rr_ptr_d   = ~w_owner;
    end else if (w_done) begin
      dp_state_d = DP_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_state_q   <= DP_IDLE;
      dp_owner_q   <= 1'b0;
      addr_lock_q  <= 1'b0;
      lock_owner_q <= 1'b0;
      rr_ptr_q     <= 1'b0;
      hwdata_q     <= '0;
    end else begin
      dp_state_q   <= dp_state_d;
      dp_owner_q   <= dp_owner_d;
      addr_lock_q  <= addr_lock_d;
      lock_owner_q <= lock_owner_d;
      rr_ptr_q     <= rr_ptr_d;
      hwdata_q     <= hwdata_d;
    end
  end

  a_be_legal: assert property (@(posedge clk) disable iff (rst)
    w_active |-> w_be_legal);

  a_lock_req_held: assert property (@(posedge clk) disable iff (rst)
    addr_lock_q |-> (lock_owner_q ? bus.p1_req_i : bus.p0_req_i));

endmodule
`default_nettype wire
